// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// ---------------------------------------------------------------------------
// Memory access controller between the CPU datapath and a 16-bit-word RAM
// with combinational read and level-sensitive write. It accepts one load or
// store at a time through a valid/ready handshake. The RAM enables are
// sequenced so that each one is active for exactly one cycle per word.
// A 32-bit access is split into a low word at addr and a high word at addr+1.
// The high-word address wraps modulo 2^ADDR_W. Completion is signalled by a
// one-cycle resp_valid pulse.
//
// Optional feature (macro MEM_CTRL_ALIGN_CHECK_EN):
//   When the macro is defined, a wide request with an odd address is rejected.
//   The FSM goes straight to RESP, no RAM enable is asserted, and resp_err is
//   raised together with resp_valid. When the macro is undefined, resp_err is
//   tied to 0.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   req_valid/ready   request handshake (ready is combinational from state)
//   req_write         1 = store, 0 = load
//   req_wide          1 = 32-bit access, 0 = 16-bit access
//   req_addr          word address
//   req_wdata         store data; [15:0] -> addr, [31:16] -> addr+1
//   resp_valid        one-cycle completion pulse
//   resp_rdata        registered load result, held until the next read
//   resp_err          request rejected (alignment check only)
//   ram_*             RAM address / data / enables and RAM read data
// ---------------------------------------------------------------------------
module mem_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_wide,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_data_in,
  output logic                ram_write_enable,
  output logic                ram_read_enable,
  input  logic [DATA_W-1:0]   ram_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nx;

  // Request captured at the handshake
  logic              wr_q;
  logic              wide_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_hi_q;   // the low store word goes straight to ram_data_in
  logic [DATA_W-1:0] rd_lo_q;      // low word of a wide read, waiting for the high word

  logic handshake;
  logic reject;
  logic busy;

  assign handshake = req_valid && req_ready;
  assign busy      = (state == LO) || (state == HI);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic err_q;
  assign reject   = req_wide && req_addr[0];
  assign resp_err = (state == RESP) && err_q;
`else
  assign reject   = 1'b0;
  assign resp_err = 1'b0;
`endif

  // The gating with rst makes the enables and the ready signal drop the
  // moment reset rises. This does not depend on the state register updating.
  assign req_ready        = (state == IDLE) && !rst;
  assign resp_valid       = (state == RESP);
  assign ram_read_enable  = busy && !wr_q   && !rst;
  assign ram_write_enable = busy &&  wr_q   && !rst;

  // NOTE: every signal written in always_comb gets a default before the case.
  // If a branch forgets a signal, this stops the tool from inferring a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (handshake) state_nx = reject ? RESP : LO;
      LO:   state_nx = wide_q ? HI : RESP;
      HI:   state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ram_address and ram_data_in are registers. Each one is loaded on the
  // edge that enters LO or HI, so it is valid for the whole of that cycle.
  // Outside LO and HI it holds the last value that was driven.
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample the pre-edge values, and the simulation order of blocks cannot
  // change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      wide_q      <= 1'b0;
      addr_q      <= '0;
      wdata_hi_q  <= '0;
      rd_lo_q     <= '0;
      resp_rdata  <= '0;
      ram_address <= '0;
      ram_data_in <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (handshake) begin
            wr_q       <= req_write;
            wide_q     <= req_wide;
            addr_q     <= req_addr;
            wdata_hi_q <= req_wdata[2*DATA_W-1:DATA_W];
`ifdef MEM_CTRL_ALIGN_CHECK_EN
            err_q      <= reject;
`endif
            if (!reject) begin
              ram_address <= req_addr;
              if (req_write) ram_data_in <= req_wdata[DATA_W-1:0];
            end
          end
        end
        LO: begin
          if (!wr_q) begin
            // A narrow read completes here. A wide read parks its low word
            // so that resp_rdata only changes once the read has finished.
            if (wide_q) rd_lo_q    <= ram_data_out;
            else        resp_rdata <= {{DATA_W{1'b0}}, ram_data_out};
          end
          if (wide_q) begin
            ram_address <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
            if (wr_q) ram_data_in <= wdata_hi_q;
          end
        end
        HI: begin
          if (!wr_q) resp_rdata <= {ram_data_out, rd_lo_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// ---------------------------------------------------------------------------
// Directed testbench for mem_ctrl. The RAM model has a combinational read and
// writes on the rising edge whenever write_enable is high. A negedge monitor
// keeps running totals of enable cycles, overlaps, responses and busy cycles.
// The main sequence compares differences of those totals against hand-computed
// expected values. Build with +define+MEM_CTRL_ALIGN_CHECK_EN to exercise the
// alignment check.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_wide;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [11:0] ram_address;
  logic [15:0] ram_data_in;
  logic        ram_write_enable;
  logic        ram_read_enable;
  logic [15:0] ram_data_out;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_wide         (req_wide),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_enable (ram_write_enable),
    .ram_read_enable  (ram_read_enable),
    .ram_data_out     (ram_data_out)
  );

  // RAM model with a backdoor preload port
  logic [15:0] mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    else if (pl_en)       mem[pl_addr]     <= pl_data;
  end
  assign ram_data_out = mem[ram_address];

  // Monitor: running totals sampled mid-cycle
  int          we_tot = 0, re_tot = 0, overlap_tot = 0, resp_tot = 0, busy_tot = 0;
  logic [11:0] last_we_addr = '0, last_re_addr = '0;

  always @(negedge clk) begin
    if (ram_write_enable) begin we_tot++; last_we_addr = ram_address; end
    if (ram_read_enable)  begin re_tot++; last_re_addr = ram_address; end
    if (ram_write_enable && ram_read_enable) overlap_tot++;
    if (resp_valid) resp_tot++;
    if (!req_ready) busy_tot++;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request. lat = the number of negedges after the handshake edge
  // up to and including the one where resp_valid is seen (narrow 2, wide 3,
  // rejected 1). It is capped at 8 if no response arrives. The task returns
  // two ns after the negedge that follows the response.
  task automatic issue(input logic w, input logic wide, input logic [11:0] a,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] rd, output logic err);
    req_valid = 1'b1; req_write = w; req_wide = wide; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 8);
    rd  = resp_rdata;
    err = resp_err;
    @(negedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          we0, re0, ov0, rs0, bz0;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;

    // Reset state
    check("reset_ready",   {31'd0, req_ready},        32'd1);
    check("reset_rvalid",  {31'd0, resp_valid},       32'd0);
    check("reset_rdata",   resp_rdata,                32'd0);
    check("reset_err",     {31'd0, resp_err},         32'd0);
    check("reset_addr",    {20'd0, ram_address},      32'd0);
    check("reset_din",     {16'd0, ram_data_in},      32'd0);
    check("reset_enables", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);

    // 1. Narrow write then narrow read at 0x010
    we0 = we_tot;
    issue(1'b1, 1'b0, 12'h010, 32'h0000_BEEF, lat, rd, err);
    check("t1_wr_lat",     lat,                       32'd2);
    check("t1_we_cycles",  we_tot - we0,              32'd1);
    check("t1_we_addr",    {20'd0, last_we_addr},     32'h010);
    check("t1_ram",        {16'd0, mem[12'h010]},     32'h0000_BEEF);
    re0 = re_tot;
    issue(1'b0, 1'b0, 12'h010, 32'h0, lat, rd, err);
    check("t1_rd_lat",     lat,                       32'd2);
    check("t1_rdata",      rd,                        32'h0000_BEEF);
    check("t1_err",        {31'd0, err},              32'd0);
    check("t1_re_cycles",  re_tot - re0,              32'd1);

    // 2. Wide write then wide read at 0x020
    we0 = we_tot;
    issue(1'b1, 1'b1, 12'h020, 32'hCAFE_1234, lat, rd, err);
    check("t2_wr_lat",     lat,                       32'd3);
    check("t2_we_cycles",  we_tot - we0,              32'd2);
    check("t2_ram_lo",     {16'd0, mem[12'h020]},     32'h1234);
    check("t2_ram_hi",     {16'd0, mem[12'h021]},     32'hCAFE);
    bz0 = busy_tot;
    issue(1'b0, 1'b1, 12'h020, 32'h0, lat, rd, err);
    check("t2_rd_lat",     lat,                       32'd3);
    check("t2_rdata",      rd,                        32'hCAFE_1234);
    check("t2_busy",       busy_tot - bz0,            32'd3);

`ifndef MEM_CTRL_ALIGN_CHECK_EN
    // 3. Wide read at 0xFFF wraps to 0x000 for the high word
    preload(12'hFFF, 16'h5555);
    preload(12'h000, 16'hAAAA);
    re0 = re_tot;
    issue(1'b0, 1'b1, 12'hFFF, 32'h0, lat, rd, err);
    check("t3_lat",        lat,                       32'd3);
    check("t3_rdata",      rd,                        32'hAAAA_5555);
    check("t3_hi_addr",    {20'd0, last_re_addr},     32'h000);
    check("t3_re_cycles",  re_tot - re0,              32'd2);
    check("t3_err",        {31'd0, err},              32'd0);
`endif

    // 4. Back-to-back reads with req_valid held high
    preload(12'h001, 16'h1111);
    preload(12'h002, 16'h2222);
    @(negedge clk); #2;
    ov0 = overlap_tot; re0 = re_tot; rs0 = resp_tot;
    req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b0; req_addr = 12'h001;
    @(posedge clk); #1;                       // first handshake
    @(negedge clk);                           // LO
    check("t4_busy_lo",    {31'd0, req_ready},        32'd0);
    @(negedge clk);                           // RESP
    check("t4_rvalid1",    {31'd0, resp_valid},       32'd1);
    check("t4_rdata1",     resp_rdata,                32'h0000_1111);
    #2 req_addr = 12'h002;
    @(negedge clk);                           // IDLE, the cycle after RESP
    check("t4_ready_after",{31'd0, req_ready},        32'd1);
    @(posedge clk); #1;                       // second handshake
    req_valid = 1'b0;
    @(negedge clk);                           // LO
    @(negedge clk);                           // RESP
    check("t4_rvalid2",    {31'd0, resp_valid},       32'd1);
    check("t4_rdata2",     resp_rdata,                32'h0000_2222);
    @(negedge clk); #2;
    check("t4_overlap",    overlap_tot - ov0,         32'd0);
    check("t4_re_cycles",  re_tot - re0,              32'd2);
    check("t4_responses",  resp_tot - rs0,            32'd2);

    // 5. Reset during the HI cycle of a wide write to 0x030
    preload(12'h030, 16'h0000);
    preload(12'h031, 16'h0BAD);
    @(negedge clk); #2;
    rs0 = resp_tot;
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1;
    req_addr = 12'h030; req_wdata = 32'h9999_7777;
    @(posedge clk); #1;                       // handshake -> LO
    req_valid = 1'b0;
    @(posedge clk); #1;                       // LO -> HI
    check("t5_hi_we",      {31'd0, ram_write_enable}, 32'd1);
    check("t5_hi_addr",    {20'd0, ram_address},      32'h031);
    rst = 1'b1;
    #1;
    check("t5_rst_enables",{30'd0, ram_write_enable, ram_read_enable}, 32'd0);
    check("t5_rst_rvalid", {31'd0, resp_valid},       32'd0);
    check("t5_rst_addr",   {20'd0, ram_address},      32'h000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_ready",      {31'd0, req_ready},        32'd1);
    check("t5_rdata_clr",  resp_rdata,                32'd0);
    repeat (3) @(negedge clk);
    #2;
    check("t5_no_resp",    resp_tot - rs0,            32'd0);
    check("t5_ram_lo",     {16'd0, mem[12'h030]},     32'h7777);
    check("t5_ram_hi",     {16'd0, mem[12'h031]},     32'h0BAD);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    // 6. Alignment check: a narrow read at 0x005 succeeds, and an odd wide
    //    read is rejected without touching the RAM or resp_rdata.
    preload(12'h005, 16'h4321);
    @(negedge clk); #2;
    issue(1'b0, 1'b0, 12'h005, 32'h0, lat, rd, err);
    check("t6_narrow_lat", lat,                       32'd2);
    check("t6_narrow_rd",  rd,                        32'h0000_4321);
    check("t6_narrow_err", {31'd0, err},              32'd0);
    we0 = we_tot; re0 = re_tot;
    issue(1'b0, 1'b1, 12'h005, 32'h0, lat, rd, err);
    check("t6_rej_lat",    lat,                       32'd1);
    check("t6_rej_err",    {31'd0, err},              32'd1);
    check("t6_rej_rdata",  rd,                        32'h0000_4321);
    check("t6_rej_ram",    (we_tot - we0) + (re_tot - re0), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
